uart_cmd_master: RTL and testbench

- Host-side initiator for the 2-byte UART register protocol served by the FPGA-side command FSM.
- Converts 12-bit register write/read requests into command bytes for a byte-level UART core, then collects the 2-byte read response.
- Used in the link-partner FPGA and as the bus-functional master in system benches.
- Sits between a request/response client and a uart core (tx_start/tx_busy, rx_data/rx_valid).

---
 rtl/uart_cmd_master.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_master.sv
// Host-side initiator for the 2-byte UART register protocol: turns 12-bit
// register write/read requests into command bytes and collects read responses.
module uart_cmd_master #(
  parameter logic [3:0]  READ_PREFIX     = 4'hA,
  parameter logic [3:0]  ALT_READ_PREFIX = 4'h8,
  parameter int unsigned TIMEOUT_CYCLES  = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [11:0] req_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [11:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, SEND, ACK, DRAIN, RX_H, RX_L, DONE, REFUSE, TOUT
  } state_t;

  state_t           state, state_d;
  logic             wr_q, wr_d;
  logic [3:0]       addr_q, addr_d;
  logic [11:0]      wdata_q, wdata_d;
  logic             b1_q, b1_d;
  logic [3:0]       hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_d, tx_start_d, rsp_valid_d, rsp_err_d;
  logic [7:0]       tx_data_d;
  logic [11:0]      rsp_rdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      b1_q      <= 1'b0;
      hi_q      <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      b1_q      <= b1_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      req_ready <= req_ready_d;
      tx_data   <= tx_data_d;
      tx_start  <= tx_start_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d     = state;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    b1_d        = b1_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data;
    tx_start_d  = 1'b0;
    rsp_rdata_d = rsp_rdata;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          b1_d    = 1'b0;
          if (req_write && (req_addr == READ_PREFIX || req_addr == ALT_READ_PREFIX))
            state_d = REFUSE;
          else
            state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          if (!wr_q)     tx_data_d = {READ_PREFIX, addr_q};
          else if (b1_q) tx_data_d = wdata_q[7:0];
          else           tx_data_d = {addr_q, wdata_q[11:8]};
          state_d = ACK;
        end
      end
      ACK: begin
        if (tx_busy) state_d = DRAIN;
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (!wr_q) begin
            state_d = RX_H;
            cnt_d   = '0;
          end else if (!b1_q) begin
            b1_d    = 1'b1;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      RX_H: begin
        if (rx_valid) begin
          hi_d    = rx_data[3:0];
          cnt_d   = '0;
          state_d = RX_L;
        end else if (cnt_q == CNT_LAST) begin
          state_d = TOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_L: begin
        // The response word is committed only once both bytes have arrived.
        if (rx_valid) begin
          rsp_rdata_d = {hi_q, rx_data};
          state_d     = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = TOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE, REFUSE, TOUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE) || (state_d == REFUSE) || (state_d == TOUT);
    rsp_err_d   = (state_d == REFUSE) || (state_d == TOUT);
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master with a simple uart core model
// (fixed frame time, busy override) and hand-computed expectations.
module tb_uart_cmd_master;

  localparam int unsigned FRAME = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr;
  logic [11:0] req_wdata;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_valid;
  logic [11:0] rsp_rdata;
  logic        rsp_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  tx_log[$];
  int          busy_cnt = 0;
  logic        hold_busy = 1'b0;
  int          illegal = 0;
  int          base;
  int          cyc;

  uart_cmd_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Uart core model: logs bytes, stays busy for FRAME cycles per byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && tx_busy) illegal++;
      if (tx_start) begin
        tx_log.push_back(tx_data);
        busy_cnt = FRAME;
      end else if (busy_cnt != 0) begin
        busy_cnt--;
      end
      tx_busy = (busy_cnt != 0) || hold_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [11:0] d);
    int n = 0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_for_issue", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rx_data = '0; rx_valid = 1'b0;
    wait_clk(1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_start",  32'(tx_start),  32'd0);
    check("rst_tx_data",   32'(tx_data),   32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    wait_clk(1);
    reset = 1'b0;
    wait_clk(1);
    check("idle_req_ready", 32'(req_ready), 32'd1);

    // Write addr 3, data 5A7
    base = tx_log.size();
    issue(1'b1, 4'h3, 12'h5A7);
    wait_rsp(200);
    check("wr_err",     32'(rsp_err), 32'd0);
    check("wr_tx_cnt",  32'(tx_log.size() - base), 32'd2);
    check("wr_b0",      32'(tx_log[base]),   32'h35);
    check("wr_b1",      32'(tx_log[base+1]), 32'hA7);
    check("wr_rdata",   32'(rsp_rdata), 32'h000);
    wait_clk(1);
    check("wr_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("wr_ready_again",   32'(req_ready), 32'd1);

    // Read addr 6, response 0B C4
    base = tx_log.size();
    issue(1'b0, 4'h6, 12'h000);
    wait_clk(30);
    check("rd_tx_cnt", 32'(tx_log.size() - base), 32'd1);
    check("rd_b0",     32'(tx_log[base]), 32'hA6);
    rx_pulse(8'h0B);
    wait_clk(3);
    rx_pulse(8'hC4);
    wait_rsp(10);
    check("rd_rdata", 32'(rsp_rdata), 32'hBC4);
    check("rd_err",   32'(rsp_err),   32'd0);
    wait_clk(1);

    // Refused writes to both read prefixes
    base = tx_log.size();
    issue(1'b1, 4'hA, 12'h123);
    check("refA_valid", 32'(rsp_valid), 32'd1);
    check("refA_err",   32'(rsp_err),   32'd1);
    wait_clk(1);
    check("refA_one_cycle", 32'(rsp_valid), 32'd0);
    issue(1'b1, 4'h8, 12'h456);
    check("ref8_valid", 32'(rsp_valid), 32'd1);
    check("ref8_err",   32'(rsp_err),   32'd1);
    wait_clk(3);
    check("ref_no_tx",  32'(tx_log.size() - base), 32'd0);
    check("ref_rdata",  32'(rsp_rdata), 32'hBC4);

    // Stray bytes while idle
    rx_pulse(8'h55);
    wait_clk(1);
    rx_pulse(8'hAA);
    wait_clk(2);
    check("idle_rx_rdata", 32'(rsp_rdata), 32'hBC4);
    check("idle_rx_valid", 32'(rsp_valid), 32'd0);

    // Busy gating: core held busy across SEND
    hold_busy = 1'b1;
    wait_clk(2);
    base = tx_log.size();
    issue(1'b1, 4'h2, 12'h7E1);
    wait_clk(50);
    check("busy_no_tx", 32'(tx_log.size() - base), 32'd0);
    hold_busy = 1'b0;
    wait_rsp(200);
    check("busy_err",    32'(rsp_err), 32'd0);
    check("busy_tx_cnt", 32'(tx_log.size() - base), 32'd2);
    check("busy_b0",     32'(tx_log[base]),   32'h27);
    check("busy_b1",     32'(tx_log[base+1]), 32'hE1);
    wait_clk(2);

    // Timeout in RX_L: only one response byte
    base = tx_log.size();
    issue(1'b0, 4'h1, 12'h000);
    wait_clk(30);
    check("to_b0", 32'(tx_log[base]), 32'hA1);
    rx_pulse(8'h01);
    wait_clk(99);
    check("to_not_yet", 32'(rsp_valid), 32'd0);
    wait_clk(1);
    check("to_valid", 32'(rsp_valid), 32'd1);
    check("to_err",   32'(rsp_err),   32'd1);
    check("to_rdata", 32'(rsp_rdata), 32'hBC4);
    wait_clk(2);

    // Asynchronous reset during RX_L
    issue(1'b0, 4'h6, 12'h000);
    wait_clk(30);
    rx_pulse(8'h0B);
    wait_clk(2);
    #2 reset = 1'b1;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_tx_start",  32'(tx_start),  32'd0);
    check("arst_tx_data",   32'(tx_data),   32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("arst_rsp_err",   32'(rsp_err),   32'd0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    check("arst_ready_after", 32'(req_ready), 32'd1);
    rx_pulse(8'hC4);
    wait_clk(1);
    check("arst_no_rsp",   32'(rsp_valid), 32'd0);
    check("arst_rdata_kept", 32'(rsp_rdata), 32'd0);

    // Read after reset, high bits of first byte ignored
    base = tx_log.size();
    issue(1'b0, 4'h9, 12'h000);
    wait_clk(30);
    check("post_b0", 32'(tx_log[base]), 32'hA9);
    rx_pulse(8'hF3);
    wait_clk(1);
    rx_pulse(8'h21);
    wait_rsp(10);
    check("post_rdata", 32'(rsp_rdata), 32'h321);
    check("post_err",   32'(rsp_err),   32'd0);

    check("no_start_while_busy", 32'(illegal), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
